// File: rtl/bp_cache_dma_responder.sv
// Memory-side responder for the L2 cache DMA channels, backed by a single-port RAM of fill words.
// Optional macro BP_CACHE_DMA_RESP_CLEAR_EN zeroes every RAM word after each reset.
module bp_cache_dma_responder #(
   parameter int unsigned daddr_width_p = 32,
   parameter int unsigned fill_width_p  = 64,
   parameter int unsigned block_width_p = 512,
   parameter int unsigned mem_els_p     = 1024,
   parameter int unsigned delay_p       = 0
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [daddr_width_p:0]   dma_pkt_i,
   input  logic                     dma_pkt_v_i,
   output logic                     dma_pkt_yumi_o,
   output logic [fill_width_p-1:0]  dma_data_o,
   output logic                     dma_data_v_o,
   input  logic                     dma_data_ready_and_i,
   input  logic [fill_width_p-1:0]  dma_data_i,
   input  logic                     dma_data_v_i,
   output logic                     dma_data_yumi_o
);

   localparam int unsigned beats_lp  = block_width_p / fill_width_p;
   localparam int unsigned offset_lp = $clog2(fill_width_p / 8);
   localparam int unsigned idx_w_lp  = $clog2(mem_els_p);
   localparam int unsigned cnt_w_lp  = $clog2(beats_lp + 1);
   localparam int unsigned dly_w_lp  = (delay_p > 0) ? $clog2(delay_p + 1) : 1;

   typedef enum logic [2:0] {
      e_ready,
      e_delay,
      e_read,
      e_write
`ifdef BP_CACHE_DMA_RESP_CLEAR_EN
      , e_clear
`endif
   } state_e;

   state_e                    state_q;
   logic [idx_w_lp-1:0]       base_q;
   logic                      wnr_q;
   logic [dly_w_lp-1:0]       dly_q;
   logic [cnt_w_lp-1:0]       cnt_q;
   logic [fill_width_p-1:0]   data_q;
   logic                      data_v_q;
   logic [fill_width_p-1:0]   mem_q [mem_els_p];
`ifdef BP_CACHE_DMA_RESP_CLEAR_EN
   logic [idx_w_lp-1:0]       clr_q;
`endif

   logic [idx_w_lp-1:0]       base_c;
   logic [idx_w_lp-1:0]       beat_addr_c;
   logic                      drain_c;
   logic                      issue_c;
   logic                      ram_we_c;
   logic [idx_w_lp-1:0]       ram_waddr_c;
   logic [fill_width_p-1:0]   ram_wdata_c;

   // Block-aligned word index; high address bits wrap modulo the RAM depth.
   assign base_c      = idx_w_lp'(dma_pkt_i[daddr_width_p-1:0] >> offset_lp)
                        & ~idx_w_lp'(beats_lp - 1);
   assign beat_addr_c = base_q + idx_w_lp'(cnt_q);

   // A read may be issued only when the output register is free by the next edge.
   assign drain_c = data_v_q & dma_data_ready_and_i;
   assign issue_c = (state_q == e_read) & (cnt_q != cnt_w_lp'(beats_lp))
                    & (~data_v_q | dma_data_ready_and_i);

   assign dma_pkt_yumi_o  = ~reset_i & (state_q == e_ready) & dma_pkt_v_i;
   assign dma_data_yumi_o = ~reset_i & (state_q == e_write) & dma_data_v_i;
   assign dma_data_o      = data_q;
   assign dma_data_v_o    = data_v_q;

   always_comb begin
      ram_we_c    = dma_data_yumi_o;
      ram_waddr_c = beat_addr_c;
      ram_wdata_c = dma_data_i;
`ifdef BP_CACHE_DMA_RESP_CLEAR_EN
      if (~reset_i && (state_q == e_clear)) begin
         ram_we_c    = 1'b1;
         ram_waddr_c = clr_q;
         ram_wdata_c = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (ram_we_c) mem_q[ram_waddr_c] <= ram_wdata_c;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
`ifdef BP_CACHE_DMA_RESP_CLEAR_EN
         state_q <= e_clear;
         clr_q   <= '0;
`else
         state_q <= e_ready;
`endif
         base_q   <= '0;
         wnr_q    <= 1'b0;
         dly_q    <= '0;
         cnt_q    <= '0;
         data_v_q <= 1'b0;
      end else begin
         case (state_q)
            e_ready: begin
               if (dma_pkt_v_i) begin
                  base_q <= base_c;
                  wnr_q  <= dma_pkt_i[daddr_width_p];
                  dly_q  <= dly_w_lp'(delay_p);
                  cnt_q  <= '0;
                  if (delay_p == 0) state_q <= dma_pkt_i[daddr_width_p] ? e_write : e_read;
                  else              state_q <= e_delay;
               end
            end
            e_delay: begin
               dly_q <= dly_q - dly_w_lp'(1);
               if (dly_q == dly_w_lp'(1)) state_q <= wnr_q ? e_write : e_read;
            end
            e_read: begin
               if (drain_c) data_v_q <= 1'b0;
               if (issue_c) begin
                  data_q   <= mem_q[beat_addr_c];
                  data_v_q <= 1'b1;
                  cnt_q    <= cnt_q + cnt_w_lp'(1);
               end
               if (drain_c && (cnt_q == cnt_w_lp'(beats_lp))) state_q <= e_ready;
            end
            e_write: begin
               if (dma_data_v_i) begin
                  cnt_q <= cnt_q + cnt_w_lp'(1);
                  if (cnt_q == cnt_w_lp'(beats_lp - 1)) state_q <= e_ready;
               end
            end
`ifdef BP_CACHE_DMA_RESP_CLEAR_EN
            e_clear: begin
               clr_q <= clr_q + idx_w_lp'(1);
               if (&clr_q) state_q <= e_ready;
            end
`endif
            default: state_q <= e_ready;
         endcase
      end
   end

endmodule
